// File: rtl/fpu_to_int.sv
// Float-to-integer unpack: converts a packed FPU word to a signed integer,
// truncating toward zero, using a one-bit-per-cycle shift FSM.
module fpu_to_int #(
    parameter int EXP_W  = 6,
    parameter int MANT_W = 25,
    parameter int BIAS   = 31,
    parameter int OUT_W  = 32
) (
    input  logic                      clock100KHz,
    input  logic                      reset,
    input  logic                      start,
    input  logic [EXP_W+MANT_W:0]     op_in,
    output logic [OUT_W-1:0]          data_out,
    output logic [3:0]                status_out,
    output logic                      busy,
    output logic                      done
);

    localparam int IN_W  = 1 + EXP_W + MANT_W;
    localparam int SIG_W = MANT_W + 1;
    localparam int ACC_W = OUT_W + MANT_W;
    localparam int CNT_W = EXP_W + 1;

    localparam logic [CNT_W-1:0] PT_C   = CNT_W'(BIAS + MANT_W);
    localparam logic [EXP_W-1:0] E_BIAS = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] E_TOP  = EXP_W'(BIAS + OUT_W - 1);

    localparam logic [3:0] ST_EXACT = 4'b0001;
    localparam logic [3:0] ST_INEX  = 4'b0010;
    localparam logic [3:0] ST_OVF   = 4'b0100;
    localparam logic [3:0] ST_UNF   = 4'b1000;

    localparam logic [OUT_W-1:0] INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SHIFT,
        SIGN
    } state_t;

    state_t              state_q;
    logic                s_q;
    logic [EXP_W-1:0]    e_q;
    logic [SIG_W-1:0]    sig_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                left_q;
    logic                sticky_q;
    logic [OUT_W-1:0]    data_q;
    logic [3:0]          status_q;
    logic                done_q;

    logic [CNT_W-1:0]    e_x;
    logic                left_d;
    logic [CNT_W-1:0]    n_d;
    logic [OUT_W-1:0]    mag_d;

    // Binary point of the accumulator sits BIAS+MANT_W bits above bit 0.
    always_comb begin
        e_x    = {1'b0, e_q};
        left_d = (e_x > PT_C);
        n_d    = left_d ? (e_x - PT_C) : (PT_C - e_x);
        mag_d  = acc_q[OUT_W-1:0];
    end

    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state_q  <= IDLE;
            s_q      <= 1'b0;
            e_q      <= '0;
            sig_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            sticky_q <= 1'b0;
            data_q   <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        s_q     <= op_in[IN_W-1];
                        e_q     <= op_in[IN_W-2:MANT_W];
                        sig_q   <= {1'b1, op_in[MANT_W-1:0]};
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (e_q == '0) begin
                        data_q   <= '0;
                        status_q <= ST_EXACT;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else if (e_q < E_BIAS) begin
                        data_q   <= '0;
                        status_q <= ST_UNF;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else if (e_q > E_TOP) begin
                        data_q   <= '0;
                        status_q <= ST_OVF;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else if (e_q == E_TOP) begin
                        // Only -2^(OUT_W-1) itself is representable here.
                        if (s_q && (sig_q[MANT_W-1:0] == '0)) begin
                            data_q   <= INT_MIN;
                            status_q <= ST_EXACT;
                        end else begin
                            data_q   <= '0;
                            status_q <= ST_OVF;
                        end
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        acc_q    <= ACC_W'(sig_q);
                        sticky_q <= 1'b0;
                        cnt_q    <= n_d;
                        left_q   <= left_d;
                        state_q  <= (n_d == '0) ? SIGN : SHIFT;
                    end
                end
                SHIFT: begin
                    if (left_q) begin
                        acc_q <= acc_q << 1;
                    end else begin
                        acc_q    <= acc_q >> 1;
                        sticky_q <= sticky_q | acc_q[0];
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    data_q   <= s_q ? (-mag_d) : mag_d;
                    status_q <= sticky_q ? ST_INEX : ST_EXACT;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out   = data_q;
    assign status_out = status_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_to_int.sv
// Bench for fpu_to_int: vector table driven back-to-back through a
// scoreboard queue, plus a reset-during-operation sequence.
module tb_fpu_to_int;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] op_in;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        busy;
    logic        done;

    int tests;
    int fails;
    int cyc;

    typedef struct {
        logic [31:0] op;
        logic [31:0] d;
        logic [3:0]  st;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  st;
        int          lat;
        int          acc;
    } exp_t;

    vec_t vt[17];
    exp_t sb[$];

    fpu_to_int dut (
        .clock100KHz (clk),
        .reset       (reset),
        .start       (start),
        .op_in       (op_in),
        .data_out    (data_out),
        .status_out  (status_out),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; the request is accepted at the next edge.
    task automatic drive(input logic [31:0] op, input logic [31:0] d,
                         input logic [3:0] st, input int lat);
        exp_t e;
        e.d   = d;
        e.st  = st;
        e.lat = lat;
        e.acc = cyc + 1;
        op_in = op;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit   got;
        exp_t e;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1;
                break;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done expected done", name);
        end else begin
            chk({name, "_data"}, data_out, e.d);
            chk({name, "_status"}, {28'd0, status_out}, {28'd0, e.st});
            chk({name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        bit saw_done;

        tests = 0;
        fails = 0;
        reset = 1'b1;
        start = 1'b0;
        op_in = '0;

        vt[0]  = '{32'h3E000000, 32'h00000001, 4'b0001, 27};
        vt[1]  = '{32'hC0400000, 32'hFFFFFFFE, 4'b0010, 26};
        vt[2]  = '{32'h7A000000, 32'h40000000, 4'b0001, 7};
        vt[3]  = '{32'h00000000, 32'h00000000, 4'b0001, 1};
        vt[4]  = '{32'h3C000000, 32'h00000000, 4'b1000, 1};
        vt[5]  = '{32'hFC000000, 32'h80000000, 4'b0001, 1};
        vt[6]  = '{32'h7C000000, 32'h00000000, 4'b0100, 1};
        vt[7]  = '{32'h7E000000, 32'h00000000, 4'b0100, 1};
        vt[8]  = '{32'h3FFFFFFF, 32'h00000001, 4'b0010, 27};
        vt[9]  = '{32'hBE000000, 32'hFFFFFFFF, 4'b0001, 27};
        vt[10] = '{32'h70000000, 32'h02000000, 4'b0001, 2};
        vt[11] = '{32'h72000000, 32'h04000000, 4'b0001, 3};
        vt[12] = '{32'h02000001, 32'h00000000, 4'b1000, 1};
        vt[13] = '{32'hFE000000, 32'h00000000, 4'b0100, 1};
        vt[14] = '{32'hFC000001, 32'h00000000, 4'b0100, 1};
        vt[15] = '{32'h40000000, 32'h00000002, 4'b0001, 26};
        vt[16] = '{32'hFBFFFFFF, 32'h80000020, 4'b0001, 7};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_data", data_out, 32'd0);
        chk("rst_status", {28'd0, status_out}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Each new start is issued in the cycle its predecessor's done is high.
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].op, vt[i].d, vt[i].st, vt[i].lat);
            wait_done($sformatf("vec%0d", i));
        end

        // Reset in the middle of a long conversion.
        op_in = 32'h3E000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_run", {31'd0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        op_in = 32'h00000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_data", data_out, 32'd0);
        chk("mid_rst_status", {28'd0, status_out}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) saw_done = 1;
            @(posedge clk);
            #1;
        end
        chk("mid_rst_quiet", {31'd0, saw_done}, 32'd0);

        drive(32'h7A000000, 32'h40000000, 4'b0001, 7);
        wait_done("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
